// File: rtl/seg_pkg.sv
// seg_pkg: segment codes and state encoding shared by the digit entry block
package seg_pkg;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    typedef enum logic [1:0] {ENTRY, HOLD, ERR} state_t;
endpackage

// File: rtl/seg_digit_entry_if.sv
// seg_digit_entry_if: digit stream in, committed number out; echo_seg exists only with SEG_DIGIT_ENTRY_ECHO_EN
interface seg_digit_entry_if #(
    parameter int WIDTH = 32
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
    , parameter int MAX_DIGITS = 4
`endif
);
    logic [6:0] seg_in;
    logic in_valid;
    logic in_ready;
    logic commit;
    logic clear;
    logic [WIDTH-1:0] value;
    logic out_valid;
    logic out_ready;
    logic [2:0] digit_count;
    logic err;
    logic ovf;
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
    logic [7*MAX_DIGITS-1:0] echo_seg;
    modport master (output seg_in, in_valid, commit, clear, out_ready,
                    input in_ready, value, out_valid, digit_count, err, ovf, echo_seg);
    modport slave (input seg_in, in_valid, commit, clear, out_ready,
                   output in_ready, value, out_valid, digit_count, err, ovf, echo_seg);
`else
    modport master (output seg_in, in_valid, commit, clear, out_ready,
                    input in_ready, value, out_valid, digit_count, err, ovf);
    modport slave (input seg_in, in_valid, commit, clear, out_ready,
                   output in_ready, value, out_valid, digit_count, err, ovf);
`endif
endinterface

// File: rtl/seg_to_digit.sv
// seg_to_digit: decodes an active-low seven-segment code back to its decimal digit
module seg_to_digit
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] digit
);
    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (seg)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg_digit_entry.sv
// seg_digit_entry: accumulates decoded seven-segment digits (MSD first) into a binary number
// and offers it over valid/ready. Define SEG_DIGIT_ENTRY_ECHO_EN to add the echo_seg shift register.
module seg_digit_entry
    import seg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MAX_DIGITS = 4
) (
    input logic clk,
    input logic reset,
    seg_digit_entry_if.slave bus
);
    if (MAX_DIGITS < 1 || MAX_DIGITS > 9) begin : g_bad_max
        $error("MAX_DIGITS must be in 1..9");
    end
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
    localparam int ECHO_W = 7 * MAX_DIGITS;
`endif
    state_t state;
    logic [WIDTH-1:0] acc;
    logic [3:0] cnt;
    logic dv;
    logic [3:0] d;
    logic accept;
    logic room;
    logic [WIDTH-1:0] next_acc;
    seg_to_digit u_dec (.seg(bus.seg_in), .valid(dv), .digit(d));
    assign bus.in_ready = state == ENTRY;
    assign bus.digit_count = cnt[2:0];
    assign accept = bus.in_valid && bus.in_ready;
    assign room = cnt < 4'(MAX_DIGITS);
    // a commit in the same cycle as a digit must see that digit, so commit loads next_acc
    assign next_acc = accept && dv && room ? (acc << 3) + (acc << 1) + WIDTH'(d) : acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ENTRY;
            acc <= '0;
            cnt <= '0;
            bus.value <= '0;
            bus.out_valid <= 1'b0;
            bus.err <= 1'b0;
            bus.ovf <= 1'b0;
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
            bus.echo_seg <= {MAX_DIGITS{SEG_BLANK}};
`endif
        end else if (bus.clear) begin
            state <= ENTRY;
            acc <= '0;
            cnt <= '0;
            bus.out_valid <= 1'b0;
            bus.err <= 1'b0;
            bus.ovf <= 1'b0;
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
            bus.echo_seg <= {MAX_DIGITS{SEG_BLANK}};
`endif
        end else begin
            bus.ovf <= 1'b0;
            case (state)
                ENTRY: begin
                    if (accept && !dv) begin
                        state <= ERR;
                        bus.err <= 1'b1;
                    end else begin
                        acc <= next_acc;
                        if (accept && room) begin
                            cnt <= cnt + 4'd1;
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
                            bus.echo_seg <= ECHO_W'({bus.echo_seg, bus.seg_in});
`endif
                        end
                        bus.ovf <= accept && !room;
                        if (bus.commit) begin
                            bus.value <= next_acc;
                            bus.out_valid <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= ENTRY;
                        acc <= '0;
                        cnt <= '0;
                        bus.out_valid <= 1'b0;
`ifdef SEG_DIGIT_ENTRY_ECHO_EN
                        bus.echo_seg <= {MAX_DIGITS{SEG_BLANK}};
`endif
                    end
                end
                default: state <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_digit_entry.sv
// tb_seg_digit_entry: vector table, hand sequences for hold/reset corners, and random traffic against a digit-list model
module tb_seg_digit_entry;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg_digit_entry_if #(.WIDTH(32)) bus ();
    seg_digit_entry #(.WIDTH(32), .MAX_DIGITS(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [6:0] seg;
        logic iv, cm, cl, rd;
        logic [31:0] val;
        logic ov;
        logic [2:0] cnt;
        logic er, of, rdy;
    } vec_t;
    vec_t vt[$];

    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int m_digits[$];
    bit m_hold, m_err, m_ovf;
    logic [31:0] m_val;

    task automatic drive(input logic [6:0] seg, input logic iv, cm, cl, rd);
        bus.seg_in = seg;
        bus.in_valid = iv;
        bus.commit = cm;
        bus.clear = cl;
        bus.out_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", n, act, exp);
        else passed++;
    endtask

    task automatic chk_all(input string t, input logic [31:0] val, input logic ov,
                           input logic [2:0] cnt, input logic er, of, rdy);
        chk($sformatf("%s.value", t), bus.value, val);
        chk($sformatf("%s.out_valid", t), 32'(bus.out_valid), 32'(ov));
        chk($sformatf("%s.digit_count", t), 32'(bus.digit_count), 32'(cnt));
        chk($sformatf("%s.err", t), 32'(bus.err), 32'(er));
        chk($sformatf("%s.ovf", t), 32'(bus.ovf), 32'(of));
        chk($sformatf("%s.in_ready", t), 32'(bus.in_ready), 32'(rdy));
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [31:0] number();
        logic [31:0] s = 0;
        foreach (m_digits[i]) s = s * 10 + 32'(m_digits[i]);
        return s;
    endfunction

    task automatic model_step(input logic [6:0] seg, input logic iv, cm, cl, rd);
        int dg;
        m_ovf = 0;
        if (cl) begin
            m_digits.delete();
            m_hold = 0;
            m_err = 0;
        end else if (m_err) begin
        end else if (m_hold) begin
            if (rd) begin
                m_hold = 0;
                m_digits.delete();
            end
        end else begin
            dg = decode(seg);
            if (iv && dg < 0) m_err = 1;
            else begin
                if (iv) begin
                    if (m_digits.size() < 4) m_digits.push_back(dg);
                    else m_ovf = 1;
                end
                if (cm) begin
                    m_val = number();
                    m_hold = 1;
                end
            end
        end
    endtask

    initial begin
        drive(7'h7F, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0, 1);

        vt.push_back('{7'h79, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1});
        vt.push_back('{7'h24, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1});
        vt.push_back('{7'h30, 1, 0, 0, 0, 0, 0, 3, 0, 0, 1});
        vt.push_back('{7'h19, 1, 0, 0, 0, 0, 0, 4, 0, 0, 1});
        vt.push_back('{7'h7F, 0, 1, 0, 0, 1234, 1, 4, 0, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 0, 1, 1234, 0, 0, 0, 0, 1});
        vt.push_back('{7'h10, 1, 0, 0, 0, 1234, 0, 1, 0, 0, 1});
        vt.push_back('{7'h78, 1, 1, 0, 0, 97, 1, 2, 0, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 0, 1, 97, 0, 0, 0, 0, 1});
        vt.push_back('{7'h12, 1, 0, 0, 0, 97, 0, 1, 0, 0, 1});
        vt.push_back('{7'h12, 1, 0, 0, 0, 97, 0, 2, 0, 0, 1});
        vt.push_back('{7'h12, 1, 0, 0, 0, 97, 0, 3, 0, 0, 1});
        vt.push_back('{7'h12, 1, 0, 0, 0, 97, 0, 4, 0, 0, 1});
        vt.push_back('{7'h12, 1, 0, 0, 0, 97, 0, 4, 0, 1, 1});
        vt.push_back('{7'h7F, 0, 0, 0, 0, 97, 0, 4, 0, 0, 1});
        vt.push_back('{7'h7F, 0, 1, 0, 0, 5555, 1, 4, 0, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 0, 1, 5555, 0, 0, 0, 0, 1});
        vt.push_back('{7'h7F, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1});
        vt.push_back('{7'h40, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1});
        vt.push_back('{7'h7E, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0});
        vt.push_back('{7'h7F, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1});
        vt.push_back('{7'h02, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1});
        vt.push_back('{7'h7F, 0, 1, 0, 0, 6, 1, 1, 0, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1});
        vt.push_back('{7'h7E, 1, 1, 0, 0, 6, 0, 0, 1, 0, 0});
        vt.push_back('{7'h7F, 0, 0, 1, 0, 6, 0, 0, 0, 0, 1});
        foreach (vt[i]) begin
            drive(vt[i].seg, vt[i].iv, vt[i].cm, vt[i].cl, vt[i].rd);
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].val, vt[i].ov, vt[i].cnt, vt[i].er, vt[i].of, vt[i].rdy);
        end

        // HOLD stays put for 10 cycles while digits and commits are offered
        drive(7'h30, 1, 0, 0, 0);
        tick();
        tick();
        drive(7'h7F, 0, 1, 0, 0);
        tick();
        drive(7'h19, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all($sformatf("hold%0d", i), 33, 1, 2, 0, 0, 0);
        end
        drive(7'h7F, 0, 0, 0, 1);
        tick();
        chk_all("hold_release", 33, 0, 0, 0, 0, 1);
        drive(7'h7F, 0, 1, 0, 0);
        tick();
        chk_all("hold_empty_commit", 0, 1, 0, 0, 0, 0);
        drive(7'h79, 1, 0, 1, 0);
        tick();
        chk_all("clear_from_hold", 0, 0, 0, 0, 0, 1);

        // asynchronous reset mid-entry
        drive(7'h79, 1, 0, 0, 0);
        tick();
        drive(7'h24, 1, 0, 0, 0);
        tick();
        chk_all("pre_reset", 0, 0, 2, 0, 0, 1);
        drive(7'h7F, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 chk_all("async_reset", 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(7'h7F, 0, 1, 0, 0);
        tick();
        chk_all("commit_after_reset", 0, 1, 0, 0, 0, 0);
        drive(7'h7F, 0, 0, 0, 1);
        tick();

        // random traffic against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_digits.delete();
        m_hold = 0;
        m_err = 0;
        m_ovf = 0;
        m_val = 0;
        for (int i = 0; i < 400; i++) begin
            logic [6:0] seg;
            logic iv, cm, cl, rd;
            seg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : codes[$urandom_range(0, 9)];
            iv = $urandom_range(0, 1);
            cm = $urandom_range(0, 7) == 0;
            cl = $urandom_range(0, 19) == 0;
            rd = $urandom_range(0, 1);
            drive(seg, iv, cm, cl, rd);
            tick();
            model_step(seg, iv, cm, cl, rd);
            chk_all($sformatf("rnd%0d", i), m_val, m_hold, 3'(m_digits.size()), m_err, m_ovf,
                    !m_hold && !m_err);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
